// File: rtl/flash_boot_loader_if.sv
// Flash read channel and SRAM write channel seen by the boot loader.
// The master drives the requests; the slave answers with data, valid and ack.
interface flash_boot_loader_if;
  logic [22:0] flash_addr;
  logic        flash_read_op;
  logic [31:0] flash_data;
  logic        flash_valid;
  logic [19:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_we;
  logic        sram_ack;

  modport master (
    output flash_addr, flash_read_op, sram_addr, sram_wdata, sram_we,
    input  flash_data, flash_valid, sram_ack
  );

  modport slave (
    input  flash_addr, flash_read_op, sram_addr, sram_wdata, sram_we,
    output flash_data, flash_valid, sram_ack
  );
endinterface

// File: rtl/flash_boot_loader.sv
// Boot copy engine: flash words -> SRAM, CPU held until the image is in place.
// Per word 1 + flash latency + write wait + 1 cycles; a stalled flash or SRAM times out to ERROR.
module flash_boot_loader #(
  parameter logic [22:0] FLASH_BASE = 23'h000000,
  parameter logic [19:0] SRAM_BASE  = 20'h00000,
  parameter int unsigned WORD_COUNT = 1024,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  flash_boot_loader_if.master        bus,
  output logic                       cpu_hold,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [20:0]                words_copied
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [20:0]   WLAST = 21'(WORD_COUNT);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_F, WRITE, NEXT, DONE, ERROR} state_t;

  state_t        state, state_nxt;
  logic [22:0]   faddr, faddr_nxt;
  logic [19:0]   saddr, saddr_nxt;
  logic [31:0]   wdata, wdata_nxt;
  logic          rd_op, rd_op_nxt;
  logic          we, we_nxt;
  logic          hold, hold_nxt;
  logic          bsy, bsy_nxt;
  logic          dn, dn_nxt;
  logic          err, err_nxt;
  logic [20:0]   cnt, cnt_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;

  always_comb begin
    state_nxt = state;
    faddr_nxt = faddr;
    saddr_nxt = saddr;
    wdata_nxt = wdata;
    rd_op_nxt = 1'b0;
    we_nxt    = we;
    hold_nxt  = hold;
    bsy_nxt   = bsy;
    dn_nxt    = dn;
    err_nxt   = err;
    cnt_nxt   = cnt;
    tcnt_nxt  = tcnt;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_nxt = REQ;
          faddr_nxt = FLASH_BASE;
          saddr_nxt = SRAM_BASE;
          cnt_nxt   = '0;
          rd_op_nxt = 1'b1;
          hold_nxt  = 1'b1;
          bsy_nxt   = 1'b1;
          dn_nxt    = 1'b0;
          err_nxt   = 1'b0;
        end
      end
      REQ: begin
        state_nxt = WAIT_F;
        tcnt_nxt  = '0;
      end
      WAIT_F: begin
        if (bus.flash_valid) begin
          wdata_nxt = bus.flash_data;
          we_nxt    = 1'b1;
          tcnt_nxt  = '0;
          state_nxt = WRITE;
        end else if (tcnt == TLAST) begin
          state_nxt = ERROR;
          bsy_nxt   = 1'b0;
          err_nxt   = 1'b1;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      WRITE: begin
        // an ack on the final allowed cycle still commits the word
        if (bus.sram_ack) begin
          we_nxt    = 1'b0;
          cnt_nxt   = cnt + 21'd1;
          state_nxt = NEXT;
        end else if (tcnt == TLAST) begin
          we_nxt    = 1'b0;
          state_nxt = ERROR;
          bsy_nxt   = 1'b0;
          err_nxt   = 1'b1;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      NEXT: begin
        if (cnt == WLAST) begin
          state_nxt = DONE;
          bsy_nxt   = 1'b0;
          dn_nxt    = 1'b1;
          hold_nxt  = 1'b0;
        end else begin
          faddr_nxt = faddr + 23'd4;
          saddr_nxt = saddr + 20'd1;
          rd_op_nxt = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      faddr <= '0;
      saddr <= '0;
      wdata <= '0;
      rd_op <= 1'b0;
      we    <= 1'b0;
      hold  <= 1'b1;
      bsy   <= 1'b0;
      dn    <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      faddr <= faddr_nxt;
      saddr <= saddr_nxt;
      wdata <= wdata_nxt;
      rd_op <= rd_op_nxt;
      we    <= we_nxt;
      hold  <= hold_nxt;
      bsy   <= bsy_nxt;
      dn    <= dn_nxt;
      err   <= err_nxt;
      cnt   <= cnt_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  assign bus.flash_addr    = faddr;
  assign bus.flash_read_op = rd_op;
  assign bus.sram_addr     = saddr;
  assign bus.sram_wdata    = wdata;
  assign bus.sram_we       = we;
  assign cpu_hold          = hold;
  assign busy              = bsy;
  assign done              = dn;
  assign error             = err;
  assign words_copied      = cnt;
endmodule

// File: tb/tb_flash_boot_loader.sv
// Random-latency flash/SRAM responders record every transaction; expected sequences come from the address rules.
`timescale 1ns/1ps
module tb_flash_boot_loader;
  localparam logic [22:0] FB = 23'h7FFFF8;
  localparam logic [19:0] SB = 20'hFFFFE;
  localparam int WC = 5;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        cpu_hold, busy, done, error;
  logic [20:0] words_copied;

  flash_boot_loader_if bus ();

  flash_boot_loader #(
    .FLASH_BASE(FB), .SRAM_BASE(SB), .WORD_COUNT(WC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .words_copied(words_copied)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scenario controls, written only by the main sequence
  int epoch = 0;
  bit spur_en = 1'b0;
  int f_hang_at = -1;
  int s_force_word = -1;
  int s_force_dly = 0;
  int end_cyc = 0;

  // transaction records, written only by the responders
  logic [22:0] rd_addr[$];
  logic [31:0] rd_word[$];
  logic [19:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int last_req_cyc = 0;
  int stab_err = 0;
  int rop_err = 0;
  int s_we_cyc = 0;

  int f_ep = 0, f_dly = 0;
  bit f_pend = 1'b0, f_hang = 1'b0, f_prev = 1'b0;
  logic [31:0] f_word = '0;
  int s_ep = 0, s_left = -1;
  bit s_wait = 1'b0;
  logic [19:0] s_pa = '0;
  logic [31:0] s_pd = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // flash controller model
  initial begin
    bus.flash_valid = 1'b0;
    bus.flash_data  = '0;
    forever begin
      @(negedge clk);
      if (f_ep != epoch) begin
        f_ep = epoch; f_pend = 1'b0; f_hang = 1'b0;
        rd_addr.delete(); rd_word.delete();
      end
      bus.flash_valid = 1'b0;
      if (f_pend && !f_hang) begin
        if (f_dly == 0) begin
          bus.flash_valid = 1'b1; bus.flash_data = f_word; f_pend = 1'b0;
        end else f_dly--;
      end else if (!f_pend && spur_en && $urandom_range(0, 2) == 0) begin
        bus.flash_valid = 1'b1; bus.flash_data = $urandom;
      end
      if (bus.flash_read_op) begin
        if (f_prev) rop_err++;
        f_hang = (rd_addr.size() == f_hang_at);
        rd_addr.push_back(bus.flash_addr);
        f_word = $urandom;
        f_dly = $urandom_range(0, 3);
        f_pend = 1'b1;
        last_req_cyc = cyc;
        if (!f_hang) rd_word.push_back(f_word);
      end
      f_prev = bus.flash_read_op;
    end
  end

  // SRAM model
  initial begin
    bus.sram_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (s_ep != epoch) begin
        s_ep = epoch; s_left = -1; s_wait = 1'b0; s_we_cyc = 0;
        wr_addr.delete(); wr_data.delete();
      end
      bus.sram_ack = 1'b0;
      if (bus.sram_we) begin
        if (s_wait && (bus.sram_addr !== s_pa || bus.sram_wdata !== s_pd)) stab_err++;
        if (wr_addr.size() == s_force_word) s_we_cyc++;
        if (s_left < 0)
          s_left = (wr_addr.size() == s_force_word) ? s_force_dly : int'($urandom_range(0, 3));
        if (s_left == 0) begin
          bus.sram_ack = 1'b1;
          wr_addr.push_back(bus.sram_addr);
          wr_data.push_back(bus.sram_wdata);
          s_left = -1; s_wait = 1'b0;
        end else begin
          s_left--; s_wait = 1'b1; s_pa = bus.sram_addr; s_pd = bus.sram_wdata;
        end
      end else begin
        s_left = -1; s_wait = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    epoch++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_done", done, 0);
    check("restart_error", error, 0);
    check("restart_hold", cpu_hold, 1);
    check("restart_busy", busy, 1);
  endtask

  task automatic wait_end(input bit poke);
    bit poked = 1'b0;
    int n = 0;
    while (!(done || error) && n < 500) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (poke && !poked && words_copied == 21'd1) begin
        start = 1'b1; poked = 1'b1;
      end
    end
    start = 1'b0;
    end_cyc = cyc;
    check("end_reached", done | error, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_copy();
    logic [22:0] ea;
    logic [19:0] sa;
    check("n_reads", rd_addr.size(), WC);
    check("n_writes", wr_addr.size(), WC);
    for (int i = 0; i < WC && i < rd_addr.size() && i < wr_addr.size() && i < rd_word.size(); i++) begin
      ea = FB + 23'(4 * i);
      sa = SB + 20'(i);
      check("flash_addr", rd_addr[i], ea);
      check("sram_addr", wr_addr[i], sa);
      check("sram_data", wr_data[i], rd_word[i]);
    end
    check("done", done, 1);
    check("error", error, 0);
    check("busy", busy, 0);
    check("cpu_hold", cpu_hold, 0);
    check("words_copied", words_copied, WC);
    check("we_idle", bus.sram_we, 0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_hold", cpu_hold, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_count", words_copied, 0);
    check("rst_rdop", bus.flash_read_op, 0);
    check("rst_faddr", bus.flash_addr, 0);
    check("rst_saddr", bus.sram_addr, 0);
    check("rst_wdata", bus.sram_wdata, 0);
    check("rst_we", bus.sram_we, 0);

    @(negedge clk);
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    check("rst_wins_busy", busy, 0);
    check("rst_wins_rdop", bus.flash_read_op, 0);
    rst = 1'b1; start = 1'b0;

    // random copies; first has word 0 backpressured for 5 cycles, one has a start poke
    for (int k = 0; k < 6; k++) begin
      spur_en = 1'($urandom_range(0, 1));
      s_force_word = (k == 0) ? 0 : -1;
      s_force_dly = 5;
      pulse_start();
      wait_end(k == 1 || $urandom_range(0, 3) == 0);
      check_copy();
      if (k == 0) check("bp_we_cycles", s_we_cyc, 6);
    end

    // flash never answers word index 1
    s_force_word = -1;
    f_hang_at = 1;
    pulse_start();
    wait_end(1'b0);
    check("ft_latency", end_cyc - last_req_cyc, TO + 1);
    repeat (5) @(negedge clk);
    check("ft_error", error, 1);
    check("ft_done", done, 0);
    check("ft_busy", busy, 0);
    check("ft_hold", cpu_hold, 1);
    check("ft_count", words_copied, 1);
    check("ft_reads", rd_addr.size(), 2);
    check("ft_writes", wr_addr.size(), 1);

    f_hang_at = -1;
    pulse_start();
    wait_end(1'b0);
    check_copy();

    // SRAM never acks word index 3
    s_force_word = 3;
    s_force_dly = 1000;
    pulse_start();
    wait_end(1'b0);
    check("st_error", error, 1);
    check("st_count", words_copied, 3);
    check("st_we", bus.sram_we, 0);
    check("st_hold", cpu_hold, 1);

    // reset during WRITE of word index 2
    s_force_word = 2;
    s_force_dly = 6;
    pulse_start();
    begin
      int n = 0;
      while (!(bus.sram_we && words_copied == 21'd2) && n < 300) begin
        @(negedge clk);
        n++;
      end
    end
    check("mr_reach", bus.sram_we && words_copied == 21'd2, 1);
    rst = 1'b0;
    @(negedge clk);
    check("mr_we", bus.sram_we, 0);
    check("mr_count", words_copied, 0);
    check("mr_hold", cpu_hold, 1);
    check("mr_busy", busy, 0);
    check("mr_rdop", bus.flash_read_op, 0);
    rst = 1'b1;
    s_force_word = -1;
    pulse_start();
    wait_end(1'b0);
    check_copy();

    check("we_stability", stab_err, 0);
    check("rdop_one_cycle", rop_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/flash_boot_loader.md
Name: flash_boot_loader

Overview:
- Boot-time copy engine that sits directly upstream of the flash controller.
- On start, it issues word reads to the flash controller and collects each 32-bit word. It then writes each word into base SRAM through a simple request/ack write port.
- It holds the CPU in boot-hold until the whole image is copied, so the processor can execute from SRAM at full speed.

Parameters:
- FLASH_BASE, 23'h000000, byte address in flash of the first image word (bits [1:0] must be 0).
- SRAM_BASE, 20'h00000, word address in SRAM of the first destination word.
- WORD_COUNT, 1024, number of 32-bit words to copy (range 1..2^20).
- TIMEOUT, 64, maximum cycles to wait for flash_valid or sram_ack before declaring an error.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-low (asserted when 0).
- start  in  1  one-cycle pulse that begins a copy; ignored unless in IDLE, DONE or ERROR.
- flash_addr  out  23  byte address presented to the flash controller bus_addr.
- flash_read_op  out  1  read request to the flash controller.
- flash_data  in  32  word returned by the flash controller.
- flash_valid  in  1  flash_data holds the word for the current request.
- sram_addr  out  20  SRAM word address.
- sram_wdata  out  32  SRAM write data.
- sram_we  out  1  SRAM write request; held until sram_ack.
- sram_ack  in  1  SRAM write accepted this cycle.
- cpu_hold  out  1  stalls the CPU while 1.
- busy  out  1  copy in progress.
- done  out  1  copy completed successfully; sticky until the next start or reset.
- error  out  1  timeout occurred; sticky until the next start or reset.
- words_copied  out  21  count of words committed to SRAM.

Behaviour:
- Reset (rst=0 at a clock edge), regardless of current state:
  - state=IDLE; all request outputs deasserted.
  - flash_addr=0, sram_addr=0, sram_wdata=0, words_copied=0.
  - busy=0, done=0, error=0.
  - cpu_hold=1: the CPU stays held after reset until a copy succeeds.
  - Reset mid-copy abandons the transfer; the state of partially written SRAM is undefined.
- States: IDLE, REQ, WAIT_F, WRITE, NEXT, DONE, ERROR.
- IDLE: on start=1, go to REQ. Load flash_addr=FLASH_BASE, sram_addr=SRAM_BASE, words_copied=0. Set busy=1.
- REQ: assert flash_read_op=1 for exactly one cycle, then go to WAIT_F. Clear the timeout counter.
- WAIT_F:
  - flash_read_op=0; flash_addr holds stable for the whole wait.
  - On flash_valid=1, capture flash_data into sram_wdata and go to WRITE.
  - If the timeout counter reaches TIMEOUT first, go to ERROR.
  - flash_valid seen in any other state is ignored.
- WRITE:
  - sram_we=1 with sram_addr and sram_wdata stable.
  - On sram_ack=1, in the same edge: sram_we drops next cycle, words_copied increments, go to NEXT.
  - If the timeout counter (restarted on entry) reaches TIMEOUT first, go to ERROR.
- NEXT:
  - If words_copied == WORD_COUNT, go to DONE.
  - Otherwise flash_addr += 4, sram_addr += 1, and go to REQ.
- Address wrap-around: both address increments wrap modulo their width, with no flag raised.
- Per-word latency: 1 (REQ) + flash latency + 1 or more (WRITE) + 1 (NEXT) cycles.
- DONE: busy=0, done=1, cpu_hold=0.
- ERROR: busy=0, error=1, cpu_hold stays 1. words_copied freezes at the last committed word.
- Restart: start in DONE or ERROR behaves as in IDLE. It clears done and error, and sets cpu_hold=1 and busy=1 on the next cycle.
- start while busy: ignored, with no effect on counters.
- Simultaneous rst=0 and start=1: reset wins.
- Every output is registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release, no start -> cpu_hold=1, busy=0, done=0, error=0, words_copied=0, flash_read_op=0.
- Basic copy: WORD_COUNT=4, FLASH_BASE=23'h000100, SRAM_BASE=20'h00010. Flash model returns addr-derived data 4 cycles after read_op; SRAM acks 1 cycle after we. Required:
  - flash_addr takes 0x100, 0x104, 0x108, 0x10C.
  - sram_addr takes 0x10..0x13 with matching data.
  - done=1 and cpu_hold=0 after the 4th ack; words_copied=4.
- Flash timeout: TIMEOUT=8, flash model never returns valid on word 2 -> error=1 exactly 8 cycles after entering WAIT_F; words_copied=1, cpu_hold=1, no further read_op.
- SRAM backpressure: withhold sram_ack for 5 cycles on word 0 (TIMEOUT=64) -> sram_we, addr and data stay stable for all 6 cycles; exactly one increment of words_copied; copy completes normally.
- Start while busy / restart: pulse start during word 1 -> no change in the sequence. After done, pulse start -> done=0, cpu_hold=1 next cycle, and the sequence restarts from FLASH_BASE.
- Mid-copy reset: assert rst=0 during WRITE of word 2 -> next cycle state=IDLE, sram_we=0, words_copied=0, cpu_hold=1. A subsequent start copies the full image from word 0.
